regdeslo_seq: RTL and testbench
===============================

# regdeslo_seq

Command sequencer for the team's 8-bit shift register (op codes: 0 hold, 1 shift left, 2 shift right, 3 parallel load).
- Accepts load, shift and load-then-shift commands over a valid/ready handshake.
- Drives the register's `op`, `in_serial` and `in_paralelo` inputs cycle by cycle.
- Reports completion with a one-cycle `done` pulse.
- Sits between the user-facing control logic and the shift register, so no other block drives the register directly.

## Interface
- `CNT_W`, default 4: width of the shift-count field; maximum shift count per command is 2^CNT_W-1.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command this cycle.
- `cmd_kind` input 2: command kind.
  - 0 = LOAD.
  - 1 = SHL (shift left).
  - 2 = SHR (shift right).
  - 3 = LDSHL (load, then shift left).
- `cmd_data` input 8: parallel value for LOAD/LDSHL.
- `cmd_count` input CNT_W: number of one-place shifts for SHL/SHR/LDSHL; ignored for LOAD.
- `op` output 2: op code to the shift register.
- `in_serial` output 1: shift enable to the shift register; 1 only during shift cycles.
- `in_paralelo` output 8: latched `cmd_data`, stable from acceptance until the next accepted LOAD/LDSHL.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `cmd_ready`=1, `op`=0, `in_serial`=0.
  - On `cmd_valid`: latch kind and count, and latch data for LOAD/LDSHL.
  - Next state: LOAD for kinds 0/3; SHIFT for kinds 1/2 if count≠0; DONE for kinds 1/2 if count=0.
- LOAD (exactly one cycle):
  - `op`=3, `in_serial`=0.
  - Next state: DONE for LOAD, or for LDSHL with count=0; otherwise SHIFT with direction left.
- SHIFT (one cycle per step):
  - `op`=1 (left) or 2 (right), `in_serial`=1.
  - Internal remaining counter loads the latched count and decrements each SHIFT cycle.
  - Leave to DONE in the cycle where remaining reaches 1, so exactly `count` shift cycles are issued.
- DONE (exactly one cycle): `op`=0, `in_serial`=0, `done`=1, `busy`=1; next state IDLE.
- `cmd_ready` = (state==IDLE).
  - Commands presented while busy are not accepted; the requester holds `cmd_valid` and the command is accepted in the first IDLE cycle.
- Back-to-back commands: after DONE, at least one IDLE cycle with `op`=0 precedes the next LOAD/SHIFT.
- `cmd_data`, `cmd_kind` and `cmd_count` changes after acceptance have no effect on the command in progress.
- `in_paralelo` changes only on acceptance of LOAD/LDSHL. SHL/SHR leave it unchanged.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state IDLE, `cmd_ready`=1.
  - `op`=0, `in_serial`=0, `in_paralelo`=8'h00.
  - `busy`=0, `done`=0, remaining counter 0.
- Reset mid-command: abort in the next cycle, no `done` pulse, `op` returns to 0 immediately; the partially shifted register content is not restored.
- `rst` has priority over command acceptance in the same cycle.
- All outputs are registered or decoded from registered state only; no combinational path from `cmd_*` to `op`/`in_serial`.
- Cycle counts, with acceptance at edge T:

| Command | Shift cycles | `done` cycle | `cmd_ready` high again |
|---|---|---|---|
| LOAD | none (`op`=3 at T+1) | T+2 | T+3 |
| SHL/SHR, count=N≥1 | T+1..T+N | T+N+1 | T+N+2 |
| SHL/SHR, count=0 | none | T+1 | T+2 |
| LDSHL, count=N | T+2..T+N+1 (after load at T+1) | T+N+2 | T+N+3 |

- Maximum count 2^CNT_W-1 (15 at default) must not wrap the counter.

## Test plan
- Reset: assert `rst` 2 cycles → `op`=0, `in_serial`=0, `in_paralelo`=00, `busy`=0, `done`=0, `cmd_ready`=1.
- LOAD 8'hA5 → `op`=3 for exactly one cycle with `in_paralelo`=A5.
  - Next cycle `done`=1.
  - Register model reads A5.
- LDSHL data 8'h81, count 3 → `op`=3 once, then `op`=1/`in_serial`=1 for exactly 3 cycles, then `done`.
  - Register model reads 8'h08.
- SHR count 0 → no `op`=1/2 cycle, `done` one cycle after acceptance. SHR count 15 → 15 shift cycles, `done` at T+16.
- Hold `cmd_valid` with SHL count 2 while an LDSHL count 5 is running → `cmd_ready`=0 throughout; the SHL is accepted in the first IDLE cycle.
  - Exactly 2 further left-shift cycles follow.
- Assert `rst` during the 2nd SHIFT cycle of SHL count 6 → `op`=0 next cycle, no `done` pulse, `cmd_ready`=1 after reset release.
  - A new LOAD 8'h3C then completes normally.

Source files
------------

// File: rtl/regdeslo_seq.sv
// ---------------------------------------------------------------------------
// regdeslo_seq
//
// Command sequencer in front of the 8-bit shift register
// (register op codes: 0 hold, 1 shift left, 2 shift right, 3 parallel load).
// Turns LOAD / SHL / SHR / LDSHL commands, accepted over a valid/ready
// handshake, into the per-cycle op / in_serial / in_paralelo drive the
// register expects. Completion is flagged with a one-cycle done pulse.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    sequencer accepts a command this cycle (state IDLE)
//   cmd_kind     0 LOAD, 1 SHL, 2 SHR, 3 LDSHL (load then shift left)
//   cmd_data     parallel value for LOAD / LDSHL
//   cmd_count    number of one-place shifts (ignored for LOAD)
//   op           op code to the shift register
//   in_serial    shift enable, high only during shift cycles
//   in_paralelo  latched cmd_data, changes only on LOAD/LDSHL acceptance
//   busy         FSM not in IDLE
//   done         one-cycle completion pulse
//
// Every output is decoded from registered state only, so nothing on the
// cmd_* inputs can reach op / in_serial combinationally.
// ---------------------------------------------------------------------------
module regdeslo_seq #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_kind,
   input  logic [7:0]       cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [1:0]       op,
   output logic             in_serial,
   output logic [7:0]       in_paralelo,
   output logic             busy,
   output logic             done
);

   // Command kinds
   localparam logic [1:0] K_LOAD  = 2'd0;
   localparam logic [1:0] K_SHL   = 2'd1;
   localparam logic [1:0] K_SHR   = 2'd2;
   localparam logic [1:0] K_LDSHL = 2'd3;

   // Register op codes
   localparam logic [1:0] OP_HOLD = 2'd0;
   localparam logic [1:0] OP_SHL  = 2'd1;
   localparam logic [1:0] OP_SHR  = 2'd2;
   localparam logic [1:0] OP_LOAD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_kind;
   logic [CNT_W-1:0] r_rem;
   logic [7:0]       r_data;

   logic             w_accept;
   logic             w_cmd_is_load;
   logic             w_cmd_count_zero;

   assign w_accept         = (r_state == ST_IDLE) && cmd_valid;
   assign w_cmd_is_load    = (cmd_kind == K_LOAD) || (cmd_kind == K_LDSHL);
   assign w_cmd_count_zero = (cmd_count == '0);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      op           = OP_HOLD;
      in_serial    = 1'b0;
      cmd_ready    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               if (w_cmd_is_load) begin
                  w_state_next = ST_LOAD;
               end else if (w_cmd_count_zero) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_SHIFT;
               end
            end
         end

         ST_LOAD: begin
            op = OP_LOAD;
            // r_rem is forced to zero for plain LOAD at acceptance, so a
            // non-zero remainder here can only come from an LDSHL.
            if ((r_kind == K_LDSHL) && (r_rem != '0)) begin
               w_state_next = ST_SHIFT;
            end else begin
               w_state_next = ST_DONE;
            end
         end

         ST_SHIFT: begin
            op        = (r_kind == K_SHR) ? OP_SHR : OP_SHL;
            in_serial = 1'b1;
            // Leaving on remaining==1 issues exactly `count` shift cycles.
            // The <=1 test also guards against a stuck FSM should r_rem
            // ever be zero here.
            if (r_rem <= CNT_W'(1)) begin
               w_state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch: kind and remaining shift count
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_kind <= K_LOAD;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_kind <= cmd_kind;
         r_rem  <= (cmd_kind == K_LOAD) ? '0 : cmd_count;
      end else if (r_state == ST_SHIFT) begin
         // Never decrements below zero: the FSM leaves SHIFT at 1.
         if (r_rem != '0) begin
            r_rem <= r_rem - CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Parallel data latch; SHL/SHR leave the previous value in place
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 8; gi++) begin : g_data
      always_ff @(posedge clk) begin
         if (rst) begin
            r_data[gi] <= 1'b0;
         end else if (w_accept && w_cmd_is_load) begin
            r_data[gi] <= cmd_data[gi];
         end
      end
   end

   assign in_paralelo = r_data;

endmodule

// File: tb/tb_regdeslo_seq.sv
module tb_regdeslo_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_kind = 2'd0;
   logic [7:0] cmd_data = 8'h00;
   logic [3:0] cmd_count = 4'd0;
   logic [1:0] op;
   logic       in_serial;
   logic [7:0] in_paralelo;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;

   regdeslo_seq #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_kind(cmd_kind), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .op(op), .in_serial(in_serial), .in_paralelo(in_paralelo),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Model of the downstream 8-bit shift register, fed by the DUT outputs.
   logic [7:0] sreg = 8'h00;
   always @(posedge clk) begin
      case (op)
         2'd1: sreg <= {sreg[6:0], 1'b0};
         2'd2: sreg <= {1'b0, sreg[7:1]};
         2'd3: sreg <= in_paralelo;
         default: sreg <= sreg;
      endcase
   end

   // Per-cycle expected/observed traces: {op, in_serial, done, busy, ready, in_paralelo}
   logic [13:0] exp_q[$];
   logic [13:0] obs_q[$];
   logic [7:0]  exp_pl   = 8'h00;
   int          exp_sreg = 0;

   function automatic logic [13:0] pk(input logic [1:0] o, input logic s, input logic d,
                                      input logic b, input logic r, input logic [7:0] p);
      return {o, s, d, b, r, p};
   endfunction

   // Reference model: cycle trace a command produces, starting the cycle
   // after acceptance and ending with the first IDLE cycle afterwards.
   task automatic build_exp(input int kind, input int data, input int cnt);
      int n;
      bit is_load;
      is_load = (kind == 0) || (kind == 3);
      n = (kind == 0) ? 0 : cnt;
      if (is_load) begin
         exp_pl = data[7:0];
         exp_q.push_back(pk(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, exp_pl));
         exp_sreg = data;
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pk((kind == 2) ? 2'd2 : 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, exp_pl));
         exp_sreg = (kind == 2) ? exp_sreg / 2 : (exp_sreg * 2) % 256;
      end
      exp_q.push_back(pk(2'd0, 1'b0, 1'b1, 1'b1, 1'b0, exp_pl));
      exp_q.push_back(pk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp_pl));
   endtask

   // Present a command at a negedge, wait (bounded) for ready, return just
   // after the accepting posedge.
   task automatic present(input int kind, input int data, input int cnt);
      int w;
      cmd_valid = 1'b1;
      cmd_kind  = kind[1:0];
      cmd_data  = data[7:0];
      cmd_count = cnt[3:0];
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: cmd_ready=%b, required 1", cmd_ready);
      end
      @(posedge clk);
   endtask

   // Drop valid and scramble fields: must not affect the command in flight.
   task automatic drop_and_scramble();
      cmd_valid = 1'b0;
      cmd_kind  = 2'($urandom);
      cmd_data  = 8'($urandom);
      cmd_count = 4'($urandom);
   endtask

   // Record n negedge samples; the first sample is taken immediately.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         if (i != 0) @(negedge clk);
         obs_q.push_back({op, in_serial, done, busy, cmd_ready, in_paralelo});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (op !== 2'd0)          begin fails++; $display("FAIL reset_op: got %0d want 0", op); end
      tests++; if (in_serial !== 1'b0)   begin fails++; $display("FAIL reset_in_serial: got %b want 0", in_serial); end
      tests++; if (in_paralelo !== 8'h00) begin fails++; $display("FAIL reset_in_paralelo: got %h want 00", in_paralelo); end
      tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (cmd_ready !== 1'b1)   begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      rst = 1'b0;
      $display("[TB] reset checked");
   endtask

   task automatic test_load();
      exp_q.delete(); obs_q.delete();
      build_exp(0, 8'hA5, 0);
      present(0, 8'hA5, 7);
      @(negedge clk);
      drop_and_scramble();
      capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL load_trace c%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests++;
      if (sreg !== 8'(exp_sreg)) begin fails++; $display("FAIL load_sreg: got %h want %h", sreg, 8'(exp_sreg)); end
      $display("[TB] LOAD A5 -> sreg %h", sreg);
   endtask

   task automatic test_ldshl();
      exp_q.delete(); obs_q.delete();
      build_exp(3, 8'h81, 3);
      present(3, 8'h81, 3);
      @(negedge clk);
      drop_and_scramble();
      capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL ldshl_trace c%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests++;
      if (sreg !== 8'h08) begin fails++; $display("FAIL ldshl_sreg: got %h want 08", sreg); end
      $display("[TB] LDSHL 81 x3 -> sreg %h", sreg);
   endtask

   task automatic test_shr();
      int cnts[2] = '{0, 15};
      foreach (cnts[k]) begin
         exp_q.delete(); obs_q.delete();
         build_exp(2, 0, cnts[k]);
         present(2, 8'h5A, cnts[k]);
         @(negedge clk);
         drop_and_scramble();
         capture(exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
               fails++;
               $display("FAIL shr%0d_trace c%0d: got %h want %h", cnts[k], i, obs_q[i], exp_q[i]);
            end
         end
         tests++;
         if (sreg !== 8'(exp_sreg)) begin fails++; $display("FAIL shr%0d_sreg: got %h want %h", cnts[k], sreg, 8'(exp_sreg)); end
         $display("[TB] SHR x%0d -> sreg %h", cnts[k], sreg);
      end
   endtask

   task automatic test_back_to_back();
      exp_q.delete(); obs_q.delete();
      build_exp(3, 8'hC3, 5);
      build_exp(1, 0, 2);
      present(3, 8'hC3, 5);
      @(negedge clk);
      // SHL held valid while the LDSHL runs; accepted in the first IDLE cycle.
      cmd_valid = 1'b1; cmd_kind = 2'd1; cmd_data = 8'hFF; cmd_count = 4'd2;
      capture(1 + 5 + 1 + 1);
      @(negedge clk);
      drop_and_scramble();
      capture(2 + 1 + 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL b2b_trace c%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests++;
      if (sreg !== 8'(exp_sreg)) begin fails++; $display("FAIL b2b_sreg: got %h want %h", sreg, 8'(exp_sreg)); end
      $display("[TB] LDSHL C3 x5 then held SHL x2 -> sreg %h", sreg);
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      // SHL by 6 aborted after two shift cycles.
      present(1, 0, 6);
      @(negedge clk);
      drop_and_scramble();
      @(negedge clk);
      tests++;
      if (op !== 2'd1) begin fails++; $display("FAIL rstmid_shift2_op: got %0d want 1", op); end
      exp_sreg = (exp_sreg * 4) % 256;
      rst = 1'b1;
      saw_done = 1'b0;
      @(negedge clk);
      saw_done |= done;
      tests++;
      if ({op, in_serial, busy} !== 4'b0000) begin fails++; $display("FAIL rstmid_abort: got op=%0d ser=%b busy=%b want 0 0 0", op, in_serial, busy); end
      @(negedge clk);
      saw_done |= done;
      rst = 1'b0;
      @(negedge clk);
      saw_done |= done;
      tests++;
      if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
      tests++;
      if (saw_done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", saw_done); end
      tests++;
      if (sreg !== 8'(exp_sreg)) begin fails++; $display("FAIL rstmid_sreg: got %h want %h", sreg, 8'(exp_sreg)); end
      // Reset cleared in_paralelo; a fresh LOAD must complete normally.
      exp_pl = 8'h00;
      exp_q.delete(); obs_q.delete();
      build_exp(0, 8'h3C, 0);
      present(0, 8'h3C, 0);
      @(negedge clk);
      drop_and_scramble();
      capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL rstmid_load_trace c%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests++;
      if (sreg !== 8'h3C) begin fails++; $display("FAIL rstmid_load_sreg: got %h want 3c", sreg); end
      $display("[TB] reset mid-SHL, then LOAD 3C -> sreg %h", sreg);
   endtask

   task automatic test_random();
      int kind, data, cnt;
      for (int t = 0; t < 25; t++) begin
         kind = $urandom_range(0, 3);
         data = $urandom_range(0, 255);
         cnt  = $urandom_range(0, 15);
         exp_q.delete(); obs_q.delete();
         build_exp(kind, data, cnt);
         present(kind, data, cnt);
         @(negedge clk);
         drop_and_scramble();
         capture(exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
               fails++;
               $display("FAIL rand%0d_trace c%0d: got %h want %h", t, i, obs_q[i], exp_q[i]);
            end
         end
         tests++;
         if (sreg !== 8'(exp_sreg)) begin fails++; $display("FAIL rand%0d_sreg: got %h want %h", t, sreg, 8'(exp_sreg)); end
         $display("[TB] rand %0d kind=%0d data=%h cnt=%0d -> sreg %h", t, kind, data[7:0], cnt, sreg);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      @(negedge clk);
      test_load();
      test_ldshl();
      test_shr();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
